// File: rtl/wash_controller.sv
// Washer program sequencer: settings, wash/rinse/spin FSM, status lamps, BCD remaining time.
// Latency: every output is registered and reflects its inputs on the next clk edge.
// Backpressure: none; pulses arriving in states that do not use them are dropped.
module wash_controller #(
    parameter int WASH_T  = 9,
    parameter int RINSE_T = 6,
    parameter int DRAIN_T = 3,
    parameter int SPIN_T  = 5,
    parameter int BEEP_T  = 3
) (
    input  logic       clk,
    input  logic       resetBtn,
    input  logic       tick,
    input  logic       runBtn,
    input  logic       WBtn,
    input  logic       RBtn,
    input  logic       DBtn,
    input  logic       WaterBtn,
    input  logic       openBtn,
    output logic       powerLED,
    output logic       runLED,
    output logic       setLED,
    output logic       beeLED,
    output logic       inWaterLED,
    output logic       outWaterLED,
    output logic       spinLED,
    output logic       WLED,
    output logic       RLED,
    output logic       DLED,
    output logic       openLED,
    output logic [2:0] level,
    output logic [7:0] remainBCD
);

    localparam logic [3:0] SET     = 4'd0;
    localparam logic [3:0] FILL_W  = 4'd1;
    localparam logic [3:0] WASH    = 4'd2;
    localparam logic [3:0] DRAIN_W = 4'd3;
    localparam logic [3:0] FILL_R  = 4'd4;
    localparam logic [3:0] RINSE   = 4'd5;
    localparam logic [3:0] DRAIN_R = 4'd6;
    localparam logic [3:0] SPIN    = 4'd7;
    localparam logic [3:0] PAUSE   = 4'd8;
    localparam logic [3:0] DONE    = 4'd9;

    localparam logic [2:0] LEVEL_RST = 3'd3;

    // Program length shown in SET for the given enables and water level.
    function automatic logic [6:0] totalTime(input logic w, input logic r,
                                             input logic d, input logic [2:0] lv);
        logic [6:0] t;
        t = '0;
        if (w) t = t + 7'(lv) + 7'(WASH_T + DRAIN_T);
        if (r) t = t + 7'(lv) + 7'(RINSE_T + DRAIN_T);
        if (d) t = t + 7'(SPIN_T);
        return t;
    endfunction

    // Tick count a state lasts once entered; fills take as long as the level.
    function automatic logic [6:0] phaseLen(input logic [3:0] st, input logic [2:0] lv);
        logic [6:0] n;
        case (st)
            FILL_W, FILL_R:   n = 7'(lv);
            WASH:             n = 7'(WASH_T);
            RINSE:            n = 7'(RINSE_T);
            DRAIN_W, DRAIN_R: n = 7'(DRAIN_T);
            SPIN:             n = 7'(SPIN_T);
            DONE:             n = 7'(BEEP_T);
            default:          n = 7'd0;
        endcase
        return n;
    endfunction

    // Remaining time never exceeds 99, so tens and units each fit a nibble.
    function automatic logic [7:0] toBcd(input logic [6:0] v);
        int q;
        int r;
        q = int'(v) / 10;
        r = int'(v) % 10;
        return {4'(q), 4'(r)};
    endfunction

    logic [3:0] state, stateNext, savedState, savedNext;
    logic [6:0] cnt, cntNext, remain, remainNext;
    logic       wEn, rEn, dEn, wNext, rNext, dNext;
    logic [2:0] levelReg, levelNext;
    logic       openReg, openNext;
    logic       enter;
    logic       runningNext;

    // Next-state logic: runBtn has priority over every other pulse, then tick.
    always_comb begin
        stateNext  = state;
        savedNext  = savedState;
        cntNext    = cnt;
        remainNext = remain;
        wNext      = wEn;
        rNext      = rEn;
        dNext      = dEn;
        levelNext  = levelReg;
        openNext   = openReg;
        enter      = 1'b0;
        case (state)
            SET: begin
                if (runBtn) begin
                    if (!openReg && (wEn || rEn || dEn)) begin
                        stateNext = wEn ? FILL_W : (rEn ? FILL_R : SPIN);
                        enter     = 1'b1;
                    end
                end else begin
                    if (WBtn) wNext = ~wEn;
                    if (RBtn) rNext = ~rEn;
                    if (DBtn) dNext = ~dEn;
                    if (WaterBtn) levelNext = (levelReg == 3'd5) ? 3'd1 : levelReg + 3'd1;
                    if (openBtn) openNext = ~openReg;
                    remainNext = totalTime(wNext, rNext, dNext, levelNext);
                end
            end
            PAUSE: begin
                if (runBtn) begin
                    if (!openReg) stateNext = savedState;
                end else if (openBtn) begin
                    openNext = ~openReg;
                end
            end
            DONE: begin
                if (runBtn) begin
                    stateNext  = SET;
                    wNext      = 1'b1;
                    rNext      = 1'b1;
                    dNext      = 1'b1;
                    remainNext = totalTime(1'b1, 1'b1, 1'b1, levelReg);
                end else begin
                    if (openBtn) openNext = ~openReg;
                    if (tick) begin
                        if (cnt == 7'd1) begin
                            stateNext  = SET;
                            wNext      = 1'b1;
                            rNext      = 1'b1;
                            dNext      = 1'b1;
                            remainNext = totalTime(1'b1, 1'b1, 1'b1, levelReg);
                        end else begin
                            cntNext = cnt - 7'd1;
                        end
                    end
                end
            end
            FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN: begin
                if (runBtn) begin
                    savedNext = state;
                    stateNext = PAUSE;
                end else if (tick) begin
                    if (remain != 7'd0) remainNext = remain - 7'd1;
                    if (cnt == 7'd1) begin
                        enter = 1'b1;
                        case (state)
                            FILL_W:  stateNext = WASH;
                            WASH:    stateNext = DRAIN_W;
                            DRAIN_W: begin
                                wNext     = 1'b0;
                                stateNext = rEn ? FILL_R : (dEn ? SPIN : DONE);
                            end
                            FILL_R:  stateNext = RINSE;
                            RINSE:   stateNext = DRAIN_R;
                            DRAIN_R: begin
                                rNext     = 1'b0;
                                stateNext = dEn ? SPIN : DONE;
                            end
                            default: begin
                                dNext     = 1'b0;
                                stateNext = DONE;
                            end
                        endcase
                    end else begin
                        cntNext = cnt - 7'd1;
                    end
                end
            end
            default: stateNext = SET;
        endcase
        if (enter) cntNext = phaseLen(stateNext, levelReg);
        if (stateNext == DONE) remainNext = 7'd0;
    end

    assign runningNext = (stateNext >= FILL_W) && (stateNext <= SPIN);

    // State, settings and all lamp/display registers.
    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            state       <= SET;
            savedState  <= SET;
            cnt         <= 7'd0;
            remain      <= totalTime(1'b1, 1'b1, 1'b1, LEVEL_RST);
            remainBCD   <= toBcd(totalTime(1'b1, 1'b1, 1'b1, LEVEL_RST));
            wEn         <= 1'b1;
            rEn         <= 1'b1;
            dEn         <= 1'b1;
            levelReg    <= LEVEL_RST;
            openReg     <= 1'b0;
            runLED      <= 1'b0;
            setLED      <= 1'b1;
            beeLED      <= 1'b0;
            inWaterLED  <= 1'b0;
            outWaterLED <= 1'b0;
            spinLED     <= 1'b0;
        end else begin
            state       <= stateNext;
            savedState  <= savedNext;
            cnt         <= cntNext;
            remain      <= remainNext;
            remainBCD   <= toBcd(remainNext);
            wEn         <= wNext;
            rEn         <= rNext;
            dEn         <= dNext;
            levelReg    <= levelNext;
            openReg     <= openNext;
            runLED      <= runningNext;
            setLED      <= (stateNext == SET);
            beeLED      <= (stateNext == DONE);
            inWaterLED  <= (stateNext == FILL_W) || (stateNext == FILL_R);
            outWaterLED <= (stateNext == DRAIN_W) || (stateNext == DRAIN_R);
            spinLED     <= (stateNext == SPIN);
        end
    end

    assign powerLED = 1'b1;
    assign WLED     = wEn;
    assign RLED     = rEn;
    assign DLED     = dEn;
    assign openLED  = openReg;
    assign level    = levelReg;

endmodule

// File: tb/tb_wash_controller.sv
// Directed bench for wash_controller: settings, full program, pause/door, async reset.
// Expected values are hand-derived from the program timing.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_wash_controller;

    logic       clk = 1'b0;
    logic       resetBtn, tick, runBtn, WBtn, RBtn, DBtn, WaterBtn, openBtn;
    logic       powerLED, runLED, setLED, beeLED, inWaterLED, outWaterLED, spinLED;
    logic       WLED, RLED, DLED, openLED;
    logic [2:0] level;
    logic [7:0] remainBCD;

    int errCount = 0;
    int checkCount = 0;

    wash_controller dut (
        .clk(clk), .resetBtn(resetBtn), .tick(tick), .runBtn(runBtn),
        .WBtn(WBtn), .RBtn(RBtn), .DBtn(DBtn), .WaterBtn(WaterBtn), .openBtn(openBtn),
        .powerLED(powerLED), .runLED(runLED), .setLED(setLED), .beeLED(beeLED),
        .inWaterLED(inWaterLED), .outWaterLED(outWaterLED), .spinLED(spinLED),
        .WLED(WLED), .RLED(RLED), .DLED(DLED), .openLED(openLED),
        .level(level), .remainBCD(remainBCD)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs != exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    // One-cycle pulse on the selected inputs; returns on the following falling edge.
    task automatic pulse(input logic t, input logic r, input logic w, input logic rb,
                         input logic d, input logic wa, input logic o);
        @(negedge clk);
        tick = t; runBtn = r; WBtn = w; RBtn = rb; DBtn = d; WaterBtn = wa; openBtn = o;
        @(negedge clk);
        tick = 0; runBtn = 0; WBtn = 0; RBtn = 0; DBtn = 0; WaterBtn = 0; openBtn = 0;
    endtask

    task automatic doTick();
        pulse(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doRun();
        pulse(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic doOpen();
        pulse(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic doWater();
        pulse(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        resetBtn = 1; tick = 0; runBtn = 0; WBtn = 0; RBtn = 0; DBtn = 0;
        WaterBtn = 0; openBtn = 0;
        repeat (2) @(negedge clk);
        resetBtn = 0;
        @(negedge clk);

        // Reset state
        checkEq("rst setLED", int'(setLED), 1);
        checkEq("rst powerLED", int'(powerLED), 1);
        checkEq("rst runLED", int'(runLED), 0);
        checkEq("rst beeLED", int'(beeLED), 0);
        checkEq("rst level", int'(level), 3);
        checkEq("rst WRD", int'({WLED, RLED, DLED}), 7);
        checkEq("rst openLED", int'(openLED), 0);
        checkEq("rst remain", int'(remainBCD), 'h32);

        // Level wraps 5 -> 1; total = 1+9+3 + 1+6+3 + 5 = 28
        repeat (3) doWater();
        checkEq("lvl wrap", int'(level), 1);
        checkEq("total28", int'(remainBCD), 'h28);

        doRun();
        checkEq("run runLED", int'(runLED), 1);
        checkEq("run setLED", int'(setLED), 0);
        checkEq("run fillW", int'(inWaterLED), 1);

        for (int k = 1; k <= 28; k++) begin
            doTick();
            checkEq($sformatf("p1 remain k=%0d", k), int'(remainBCD), bcd(28 - k));
            checkEq($sformatf("p1 inW k=%0d", k), int'(inWaterLED), (k == 13) ? 1 : 0);
            checkEq($sformatf("p1 outW k=%0d", k), int'(outWaterLED),
                    ((k >= 10 && k <= 12) || (k >= 20 && k <= 22)) ? 1 : 0);
            checkEq($sformatf("p1 spin k=%0d", k), int'(spinLED), (k >= 23 && k <= 27) ? 1 : 0);
            checkEq($sformatf("p1 WLED k=%0d", k), int'(WLED), (k < 13) ? 1 : 0);
            checkEq($sformatf("p1 RLED k=%0d", k), int'(RLED), (k < 23) ? 1 : 0);
            checkEq($sformatf("p1 bee k=%0d", k), int'(beeLED), (k == 28) ? 1 : 0);
        end
        checkEq("done runLED", int'(runLED), 0);
        checkEq("done DLED", int'(DLED), 0);
        repeat (2) doTick();
        checkEq("beep 2", int'(beeLED), 1);
        doTick();
        checkEq("beep end", int'(beeLED), 0);
        checkEq("back SET", int'(setLED), 1);
        checkEq("back WRD", int'({WLED, RLED, DLED}), 7);
        checkEq("back level", int'(level), 1);
        checkEq("back remain", int'(remainBCD), 'h28);

        // Wash only, level 3: total 15
        pulse(0, 0, 0, 1, 1, 0, 0);
        checkEq("RD off", int'({WLED, RLED, DLED}), 4);
        checkEq("W only l1", int'(remainBCD), 'h13);
        repeat (2) doWater();
        checkEq("W only l3", int'(remainBCD), 'h15);
        doRun();
        for (int k = 1; k <= 5; k++) begin
            doTick();
            checkEq($sformatf("p2 remain k=%0d", k), int'(remainBCD), bcd(15 - k));
        end
        pulse(1, 1, 0, 0, 0, 0, 0);   // run with tick: pause wins, tick lost
        checkEq("pause runLED", int'(runLED), 0);
        checkEq("pause remain", int'(remainBCD), 'h10);
        doTick();
        checkEq("pause frozen", int'(remainBCD), 'h10);
        doOpen();
        checkEq("pause open", int'(openLED), 1);
        doRun();
        checkEq("open blocks resume", int'(runLED), 0);
        doOpen();
        checkEq("pause close", int'(openLED), 0);
        doRun();
        checkEq("resume runLED", int'(runLED), 1);
        checkEq("resume wash", int'(inWaterLED | outWaterLED), 0);
        repeat (7) doTick();
        checkEq("p2 drain", int'(outWaterLED), 1);
        repeat (2) doTick();
        checkEq("p2 not done", int'(beeLED), 0);
        doTick();
        checkEq("p2 done", int'(beeLED), 1);
        checkEq("p2 remain0", int'(remainBCD), 0);
        doRun();
        checkEq("done run->SET", int'(setLED), 1);
        checkEq("done run bee", int'(beeLED), 0);

        // Fresh settings from reset
        @(negedge clk); resetBtn = 1;
        @(negedge clk); resetBtn = 0;
        pulse(0, 0, 1, 1, 1, 0, 0);
        checkEq("all off", int'({WLED, RLED, DLED}), 0);
        checkEq("all off remain", int'(remainBCD), 0);
        doRun();
        checkEq("none run", int'(setLED), 1);
        pulse(0, 1, 1, 0, 0, 0, 0);
        checkEq("run+W WLED", int'(WLED), 0);
        checkEq("run+W SET", int'(setLED), 1);

        doOpen();
        pulse(0, 0, 1, 1, 0, 0, 0);
        checkEq("WR on", int'({WLED, RLED, DLED}), 6);
        checkEq("WR total", int'(remainBCD), 'h27);
        doRun();
        checkEq("door open run", int'(setLED), 1);
        doOpen();
        doRun();
        checkEq("door shut run", int'(inWaterLED), 1);
        doOpen();
        checkEq("open ignored running", int'(openLED), 0);
        repeat (20) doTick();
        checkEq("mid rinse run", int'(runLED), 1);
        checkEq("mid rinse remain", int'(remainBCD), 'h07);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 resetBtn = 1;
        #1;
        checkEq("async setLED", int'(setLED), 1);
        checkEq("async runLED", int'(runLED), 0);
        checkEq("async remain", int'(remainBCD), 'h32);
        checkEq("async WRD", int'({WLED, RLED, DLED}), 7);
        checkEq("async bee", int'(beeLED), 0);
        @(negedge clk);
        resetBtn = 0;
        @(negedge clk);
        checkEq("post rst level", int'(level), 3);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
